// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead byte FIFO onto a UART 8N1 line: one pop per frame, LSB first,
// with the line held in a register so it never glitches.
module fifo_uart_tx #(
    parameter int c_CLKS_PER_BIT = 104,
    parameter int c_DATAWIDTH    = 8
) (
    input  logic                   i_clock,
    input  logic                   i_resetn,
    input  logic                   i_fifo_empty,
    input  logic [c_DATAWIDTH-1:0] i_fifo_data,
    output logic                   o_fifo_readen,
    input  logic                   i_enable,
    output logic                   o_tx,
    output logic                   o_busy
);
    localparam int c_CW = $clog2(c_CLKS_PER_BIT);
    localparam int c_IW = (c_DATAWIDTH > 1) ? $clog2(c_DATAWIDTH) : 1;
    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(c_CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(c_DATAWIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} t_state;

    t_state                 r_state, w_state_next;
    logic [c_CW-1:0]        r_baud, w_baud_next;
    logic [c_IW-1:0]        r_idx, w_idx_next;
    logic [c_DATAWIDTH-1:0] r_shift, w_shift_next;
    logic                   r_tx, w_tx_next;
    logic                   w_readen;
    logic                   w_bit_end;
    logic [c_DATAWIDTH-1:0] w_shift_shr;

    assign w_bit_end   = (r_baud == c_BAUD_LAST);
    assign w_shift_shr = r_shift >> 1;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_tx_next    = r_tx;
        w_readen     = 1'b0;
        if (r_state != IDLE)
            w_baud_next = w_bit_end ? '0 : r_baud + c_CW'(1);
        case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                // Reset gating keeps the pop strobe quiet while the block is held in reset.
                w_readen  = i_enable && !i_fifo_empty && i_resetn;
                if (w_readen) begin
                    w_shift_next = i_fifo_data;
                    w_baud_next  = '0;
                    w_idx_next   = '0;
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_idx_next   = '0;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_shift_next = w_shift_shr;
                        w_idx_next   = r_idx + c_IW'(1);
                        w_tx_next    = w_shift_shr[0];
                    end
                end
            end
            STOP: begin
                w_tx_next = 1'b1;
                if (w_bit_end)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_fifo_readen = w_readen;
    assign o_tx          = r_tx;
    assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with 4 clocks per bit and a small show-ahead FIFO model.
module tb_fifo_uart_tx;
    localparam int N = 4;

    logic       i_clock = 1'b0;
    logic       i_resetn;
    logic       i_fifo_empty;
    logic [7:0] i_fifo_data;
    logic       o_fifo_readen;
    logic       i_enable;
    logic       o_tx;
    logic       o_busy;

    fifo_uart_tx #(.c_CLKS_PER_BIT(N), .c_DATAWIDTH(8)) dut (
        .i_clock(i_clock), .i_resetn(i_resetn), .i_fifo_empty(i_fifo_empty),
        .i_fifo_data(i_fifo_data), .o_fifo_readen(o_fifo_readen), .i_enable(i_enable),
        .o_tx(o_tx), .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    logic [7:0] mem [0:15];
    int wr = 0;
    int rd = 0;
    int cyc = 0;
    int pops = 0;
    int badpop = 0;
    int vectors = 0;
    int miscompares = 0;

    assign i_fifo_empty = (rd == wr);
    assign i_fifo_data  = mem[rd % 16];

    always @(posedge i_clock) begin
        cyc <= cyc + 1;
        if (o_fifo_readen) begin
            rd   <= rd + 1;
            pops <= pops + 1;
            if (i_fifo_empty) badpop <= badpop + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr % 16] = b;
        wr++;
    endtask

    task automatic wait_pop(output int c);
        int n;
        n = 0;
        #1;
        while (!o_fifo_readen && n < 200) begin
            tick();
            n++;
        end
        check("pop_seen", 32'(o_fifo_readen), 32'd1);
        c = cyc;
    endtask

    // Checks a full frame cycle by cycle, then the first IDLE cycle after it.
    task automatic frame(input logic [7:0] b, input int drop_at, output int c);
        logic [9:0] bits;
        logic [7:0] dec;
        bits = {1'b1, b, 1'b0};
        dec  = 8'h00;
        wait_pop(c);
        for (int k = 0; k < 10*N; k++) begin
            tick();
            if (k == drop_at) i_enable = 1'b0;
            check("frame_tx", 32'(o_tx), 32'(bits[k/N]));
            check("frame_busy", 32'(o_busy), 32'd1);
            check("frame_readen", 32'(o_fifo_readen), 32'd0);
            if ((k % N) == N/2 && k/N >= 1 && k/N <= 8) dec[k/N-1] = o_tx;
        end
        check("decoded", 32'(dec), 32'(b));
        tick();
        check("idle_tx", 32'(o_tx), 32'd1);
        check("idle_busy", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int c1, c2, p0, bad;
        i_resetn = 1'b0;
        i_enable = 1'b1;
        push(8'hA5);

        // Held in reset with a non-empty FIFO: nothing moves.
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_fifo_readen !== 1'b0) bad++;
        end
        check("reset_hold", 32'(bad), 32'd0);
        check("reset_no_pop", 32'(pops), 32'd0);
        i_resetn = 1'b1;
        #1;
        check("release_readen", 32'(o_fifo_readen), 32'd1);
        frame(8'hA5, -1, c1);
        check("a5_one_pop", 32'(pops), 32'd1);
        check("empty_readen", 32'(o_fifo_readen), 32'd0);

        // Back-to-back frames.
        push(8'h00);
        push(8'hFF);
        frame(8'h00, -1, c1);
        check("b2b_readen", 32'(o_fifo_readen), 32'd1);
        frame(8'hFF, -1, c2);
        check("b2b_spacing", 32'(c2 - c1), 32'd41);

        // Flow control.
        i_enable = 1'b0;
        push(8'h3C);
        p0 = pops;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_tx !== 1'b1 || o_fifo_readen !== 1'b0) bad++;
        end
        check("disabled_idle", 32'(bad), 32'd0);
        check("disabled_no_pop", 32'(pops - p0), 32'd0);
        i_enable = 1'b1;
        frame(8'h3C, 13, c1);
        push(8'h99);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_tx !== 1'b1 || o_fifo_readen !== 1'b0) bad++;
        end
        check("drop_no_pop", 32'(pops - p0), 32'd1);
        check("drop_idle", 32'(bad), 32'd0);
        i_enable = 1'b1;
        frame(8'h99, -1, c1);

        // Reset in the middle of data bit 3 of 0x55.
        push(8'h55);
        push(8'h0F);
        p0 = pops;
        wait_pop(c1);
        for (int k = 0; k < 4*N + 2; k++) tick();
        check("mid_bit3", 32'(o_tx), 32'd0);
        i_resetn = 1'b0;
        #1;
        check("async_tx", 32'(o_tx), 32'd1);
        check("async_busy", 32'(o_busy), 32'd0);
        check("async_readen", 32'(o_fifo_readen), 32'd0);
        tick();
        tick();
        i_resetn = 1'b1;
        frame(8'h0F, -1, c1);
        check("rst_pops", 32'(pops - p0), 32'd2);

        // FIFO runs dry after two bytes.
        push(8'h12);
        push(8'h34);
        p0 = pops;
        frame(8'h12, -1, c1);
        frame(8'h34, -1, c1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_tx !== 1'b1 || o_fifo_readen !== 1'b0) bad++;
        end
        check("dry_idle", 32'(bad), 32'd0);
        check("dry_pops", 32'(pops - p0), 32'd2);
        check("never_pop_empty", 32'(badpop), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
